// File: rtl/mult_share_pkg.sv
// Shared types for the multiplier-sharing controller.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester-facing bus of the multiplier-sharing controller.
interface mult_share_ctrl_if #(
  parameter int BIT = 4
);
  logic             req0;
  logic [BIT-1:0]   a0;
  logic [BIT-1:0]   b0;
  logic             req1;
  logic [BIT-1:0]   a1;
  logic [BIT-1:0]   b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [2*BIT-1:0] res;
  logic             oflow;
  logic             busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, res, oflow, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, res, oflow, busy
  );
endinterface

// File: rtl/multiplicador.sv
// Combinational unsigned shift-add array multiplier with upper-half overflow flag.
module multiplicador #(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0]   a,
  input  logic [BIT-1:0]   b,
  output logic [2*BIT-1:0] p,
  output logic             oflow
);

  always_comb begin
    p = '0;
    for (int i = 0; i < BIT; i++) begin
      if (b[i]) p = p + ({{BIT{1'b0}}, a} << i);
    end
  end

  assign oflow = |p[2*BIT-1:BIT];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, ties go to prio.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = prio;
  end

  assign valid = |req;

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multi-cycle combinational multiplier between two requesters.
// state | meaning
// IDLE  | no owner; arbitrate and latch winner's operands
// EXEC  | operands held on the multiplier for SETTLE edges
// DONE  | product registered; one-cycle done to owner, then release
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int BIT    = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_share_ctrl_if.slave bus
);

  // Out-of-range settle counts are clamped into the supported window.
  localparam int SETTLE_C = (SETTLE < 1) ? 1 : ((SETTLE > MAX_SETTLE) ? MAX_SETTLE : SETTLE);
  localparam int CW       = $clog2(SETTLE_C + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_C - 1);

  ctrl_state_t      state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIT-1:0]   op_a_q, op_a_d;
  logic [BIT-1:0]   op_b_q, op_b_d;
  logic [2*BIT-1:0] res_q, res_d;
  logic             oflow_q, oflow_d;

  logic             arb_winner;
  logic             arb_valid;
  logic [2*BIT-1:0] mul_p;
  logic             mul_oflow;

  rr_arb2 u_arb (
    .req    ({bus.req1, bus.req0}),
    .prio   (prio_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Fed only from the held operand registers so the path can be multi-cycle.
  multiplicador #(.BIT(BIT)) u_mul (
    .a     (op_a_q),
    .b     (op_b_q),
    .p     (mul_p),
    .oflow (mul_oflow)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    oflow_d = oflow_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_winner;
          op_a_d  = arb_winner ? bus.a1 : bus.a0;
          op_b_d  = arb_winner ? bus.b1 : bus.b0;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = mul_p;
          oflow_d = mul_oflow;
          state_d = DONE;
        end
      end
      DONE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      oflow_q <= oflow_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.gnt0  = (state_q != IDLE) && !owner_q;
  assign bus.gnt1  = (state_q != IDLE) &&  owner_q;
  assign bus.done0 = (state_q == DONE) && !owner_q;
  assign bus.done1 = (state_q == DONE) &&  owner_q;
  assign bus.res   = res_q;
  assign bus.oflow = oflow_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: SETTLE=2 and SETTLE=1 instances driven by identical stimulus.
module tb_mult_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1;
  logic [3:0] a0, b0, a1, b1;

  always #5 clk = ~clk;

  mult_share_ctrl_if #(.BIT(4)) bus_s2 ();
  mult_share_ctrl_if #(.BIT(4)) bus_s1 ();

  assign bus_s2.req0 = req0;  assign bus_s1.req0 = req0;
  assign bus_s2.a0   = a0;    assign bus_s1.a0   = a0;
  assign bus_s2.b0   = b0;    assign bus_s1.b0   = b0;
  assign bus_s2.req1 = req1;  assign bus_s1.req1 = req1;
  assign bus_s2.a1   = a1;    assign bus_s1.a1   = a1;
  assign bus_s2.b1   = b1;    assign bus_s1.b1   = b1;

  mult_share_ctrl #(.BIT(4), .SETTLE(2)) u_dut_s2 (.clk(clk), .rst_n(rst_n), .bus(bus_s2));
  mult_share_ctrl #(.BIT(4), .SETTLE(1)) u_dut_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));

  logic       o_gnt0[2], o_gnt1[2], o_done0[2], o_done1[2], o_oflow[2], o_busy[2];
  logic [7:0] o_res[2];
  assign o_gnt0[0] = bus_s2.gnt0;   assign o_gnt0[1] = bus_s1.gnt0;
  assign o_gnt1[0] = bus_s2.gnt1;   assign o_gnt1[1] = bus_s1.gnt1;
  assign o_done0[0] = bus_s2.done0; assign o_done0[1] = bus_s1.done0;
  assign o_done1[0] = bus_s2.done1; assign o_done1[1] = bus_s1.done1;
  assign o_oflow[0] = bus_s2.oflow; assign o_oflow[1] = bus_s1.oflow;
  assign o_busy[0] = bus_s2.busy;   assign o_busy[1] = bus_s1.busy;
  assign o_res[0] = bus_s2.res;     assign o_res[1] = bus_s1.res;

  int n_cmp = 0;
  int n_fail = 0;
  int settle_of[2] = '{2, 1};

  // Reference: each instance is either free (left==0) or busy for SETTLE+1 more cycles,
  // the last of which is the done cycle with the freshly captured product.
  int m_left[2], m_res[2], m_pend[2];
  bit m_owner[2], m_prio[2], m_ofl[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_res[d] = 0; m_pend[d] = 0;
      m_owner[d] = 0; m_prio[d] = 0; m_ofl[d] = 0;
    end
  endtask

  task automatic model_step();
    bit w;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_left[d] = 0; m_res[d] = 0; m_owner[d] = 0; m_prio[d] = 0; m_ofl[d] = 0;
      end else if (m_left[d] == 0) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? m_prio[d] : req1;
          m_owner[d] = w;
          m_pend[d] = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
          m_left[d] = settle_of[d] + 1;
        end
      end else begin
        m_left[d]--;
        if (m_left[d] == 1) begin
          m_res[d] = m_pend[d];
          m_ofl[d] = (m_pend[d] > 15);
        end
        if (m_left[d] == 0) m_prio[d] = !m_owner[d];
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({o_gnt0[d], o_gnt1[d], o_done0[d], o_done1[d], o_oflow[d], o_busy[d], o_res[d]} !== 14'd0) begin
          n_fail++;
          $display("FAIL reset_outputs d%0d: got gnt=%b%b done=%b%b of=%b busy=%b res=%0d exp all 0", d,
                   o_gnt1[d], o_gnt0[d], o_done1[d], o_done0[d], o_oflow[d], o_busy[d], o_res[d]);
        end
      end
      tick();
    end
    req0 = 0; req1 = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({o_busy[d], o_done0[d], o_done1[d]} !== 3'b000) begin
          n_fail++;
          $display("FAIL idle_quiet d%0d c%0d: got busy=%b done=%b%b exp 0", d, c, o_busy[d], o_done1[d], o_done0[d]);
        end
      end
    end
  endtask

  // One isolated request from requester r; checks grant, done timing and result.
  task automatic run_single(input bit r, input logic [3:0] a, input logic [3:0] b,
                            input int exp_res, input bit exp_ofl);
    logic exp_done, g_own, g_oth, d_own, d_oth;
    if (r) begin req1 = 1; a1 = a; b1 = b; end else begin req0 = 1; a0 = a; b0 = b; end
    tick();
    req0 = 0; req1 = 0;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    for (int d = 0; d < 2; d++) begin
      g_own = r ? o_gnt1[d] : o_gnt0[d];
      n_cmp++;
      if (g_own !== 1'b1) begin
        n_fail++;
        $display("FAIL single_grant r%0d d%0d: got gnt=%b exp 1", r, d, g_own);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        exp_done = (k == settle_of[d]);
        g_own = r ? o_gnt1[d] : o_gnt0[d];
        g_oth = r ? o_gnt0[d] : o_gnt1[d];
        d_own = r ? o_done1[d] : o_done0[d];
        d_oth = r ? o_done0[d] : o_done1[d];
        n_cmp++;
        if ({g_own, g_oth, d_own, d_oth} !== {1'(k <= settle_of[d]), 1'b0, exp_done, 1'b0}) begin
          n_fail++;
          $display("FAIL single_timing r%0d d%0d k%0d: got gnt=%b/%b done=%b/%b exp gnt=%b/0 done=%b/0",
                   r, d, k, g_own, g_oth, d_own, d_oth, 1'(k <= settle_of[d]), exp_done);
        end
        if (exp_done) begin
          n_cmp++;
          if (o_res[d] !== 8'(exp_res) || o_oflow[d] !== exp_ofl) begin
            n_fail++;
            $display("FAIL single_result a=%0d b=%0d d%0d: got res=%0d of=%b exp res=%0d of=%b",
                     a, b, d, o_res[d], o_oflow[d], exp_res, exp_ofl);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    run_single(1'b0, 4'd7, 4'd9, 63, 1'b1);
  endtask

  task automatic test_edge_values();
    logic [3:0] ta[4] = '{4'd0, 4'd1, 4'd2, 4'd15};
    logic [3:0] tb_[4] = '{4'd15, 4'd15, 4'd8, 4'd15};
    int  tr[4] = '{0, 15, 16, 225};
    bit  to[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) run_single(1'(i % 2), ta[i], tb_[i], tr[i], to[i]);
  endtask

  task automatic test_contention();
    int  cnt[2];
    bit  who[2][4];
    int  rr[2][4];
    bit  ro[2][4];
    rst_n = 0; model_reset();
    req0 = 1; req1 = 1; a0 = 3; b0 = 5; a1 = 15; b1 = 15;
    tick();
    rst_n = 1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({o_gnt0[d], o_gnt1[d]} !== 2'b10) begin
        n_fail++;
        $display("FAIL contention_first_grant d%0d: got gnt0=%b gnt1=%b exp 1 0", d, o_gnt0[d], o_gnt1[d]);
      end
      cnt[d] = 0;
    end
    for (int c = 0; c < 40 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if ((o_done0[d] === 1'b1 || o_done1[d] === 1'b1) && cnt[d] < 4) begin
          who[d][cnt[d]] = o_done1[d];
          rr[d][cnt[d]] = int'(o_res[d]);
          ro[d][cnt[d]] = o_oflow[d];
          cnt[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (cnt[d] != 4) begin
        n_fail++;
        $display("FAIL contention_pulses d%0d: got %0d done pulses exp 4", d, cnt[d]);
      end
      for (int i = 0; i < cnt[d]; i++) begin
        n_cmp++;
        if (who[d][i] != 1'(i % 2) || rr[d][i] != ((i % 2) ? 225 : 15) || ro[d][i] != 1'(i % 2)) begin
          n_fail++;
          $display("FAIL contention_order d%0d #%0d: got who=%0d res=%0d of=%0d exp who=%0d res=%0d of=%0d",
                   d, i, who[d][i], rr[d][i], ro[d][i], i % 2, (i % 2) ? 225 : 15, i % 2);
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (6) tick();
  endtask

  task automatic test_operand_hold();
    bit seen[2] = '{1'b0, 1'b0};
    req1 = 1; a1 = 2; b1 = 3; req0 = 0;
    tick();
    a1 = 15; b1 = 15; req1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (o_done1[d] === 1'b1) begin
          seen[d] = 1;
          n_cmp++;
          if (o_res[d] !== 8'd6 || o_oflow[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL operand_hold d%0d: got res=%0d of=%b exp res=6 of=0", d, o_res[d], o_oflow[d]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (!seen[d]) begin
        n_fail++;
        $display("FAIL operand_hold_done d%0d: got no done1 exp one pulse", d);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen[2] = '{1'b0, 1'b0};
    req0 = 1; a0 = 5; b0 = 6; req1 = 0;
    tick();
    tick();
    rst_n = 0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({o_busy[d], o_gnt0[d], o_done0[d], o_oflow[d], o_res[d]} !== 12'd0) begin
          n_fail++;
          $display("FAIL reset_mid d%0d c%0d: got busy=%b gnt0=%b done0=%b of=%b res=%0d exp 0",
                   d, c, o_busy[d], o_gnt0[d], o_done0[d], o_oflow[d], o_res[d]);
        end
      end
      tick();
    end
    rst_n = 1;
    tick();
    req0 = 0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (o_gnt0[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_regrant d%0d: got gnt0=%b exp 1", d, o_gnt0[d]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (o_done0[d] === 1'b1) begin
          seen[d] = 1;
          n_cmp++;
          if (o_res[d] !== 8'd30 || o_oflow[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recover d%0d: got res=%0d of=%b exp res=30 of=1", d, o_res[d], o_oflow[d]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (!seen[d]) begin
        n_fail++;
        $display("FAIL reset_recover_done d%0d: got no done0 exp one pulse", d);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        got = {o_busy[d], o_gnt0[d], o_gnt1[d], o_done0[d], o_done1[d], o_oflow[d], 1'b0};
        exp = {1'(m_left[d] > 0), 1'(m_left[d] > 0 && !m_owner[d]), 1'(m_left[d] > 0 && m_owner[d]),
               1'(m_left[d] == 1 && !m_owner[d]), 1'(m_left[d] == 1 && m_owner[d]), m_ofl[d], 1'b0};
        n_cmp++;
        if (got !== exp || o_res[d] !== 8'(m_res[d])) begin
          n_fail++;
          $display("FAIL random d%0d c%0d: got ctl=%b res=%0d exp ctl=%b res=%0d", d, c, got, o_res[d], exp, m_res[d]);
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (6) tick();
  endtask

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_edge_values();
    test_contention();
    test_operand_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp bench completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Sequencing controller that shares one combinational array multiplier (`multiplicador`, BIT-wide operands, 2*BIT-wide product plus OFLOW flag) between two requesters. The multiplier is a long ripple path, so the controller:
- captures the winner's operands into registers,
- holds them stable for a programmable number of settle cycles (multi-cycle path),
- registers the product and returns it with a one-cycle done pulse.

It sits between two client FSMs and the shared multiplier datapath.

Parameters:
BIT, 4, operand width; forwarded to the multiplier instance.
SETTLE, 2, clock edges operands are held before the product is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req0  input  1  requester 0 request, level.
a0  input  BIT  requester 0 multiplicand.
b0  input  BIT  requester 0 multiplier.
req1  input  1  requester 1 request, level.
a1  input  BIT  requester 1 multiplicand.
b1  input  BIT  requester 1 multiplier.
gnt0  output  1  requester 0 owns the multiplier.
gnt1  output  1  requester 1 owns the multiplier.
done0  output  1  one-cycle pulse: res/oflow valid for requester 0.
done1  output  1  one-cycle pulse: res/oflow valid for requester 1.
res  output  2*BIT  registered product of the last completed operation.
oflow  output  1  registered overflow: product > 2**BIT-1.
busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (rst_n=0, asynchronous): all outputs 0; state=IDLE; operand registers 0; cnt=0; priority pointer prio=0 (requester 0 favoured).

States: IDLE, EXEC, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: that requester wins.
  - Both high: winner = prio.
  - On the grant edge: latch a/b of the winner into op_a/op_b, set owner, cnt=0, go to EXEC.
  - gnt[owner]=1 from the grant edge until leaving DONE.
- EXEC:
  - Multiplier inputs are driven only from op_a/op_b, never directly from the ports.
  - cnt increments each edge.
  - On the edge where cnt==SETTLE-1: res<=product, oflow<=(product > 2**BIT-1), go to DONE.
- DONE:
  - done[owner]=1 for exactly this cycle.
  - Next edge: go to IDLE, drop gnt, prio<=~owner.

Latency and ordering:
- Grant edge G; done asserted in the cycle after edge G+SETTLE.
- Back-to-back throughput: one result per SETTLE+2 cycles.
- res/oflow hold their value until the next completion; they never change outside that capture edge.

Handshake rules:
- Operands are sampled only on the grant edge; port changes after the grant do not affect the operation.
- A req still high in the cycle after done counts as a new request and is re-arbitrated in IDLE.
- Dropping req during EXEC does not abort; the operation completes and done still pulses.
- A requester never sees done without having first seen gnt.

Boundary conditions:
- Both requesting continuously: strict alternation 0,1,0,1...
- Single persistent requester: served every SETTLE+2 cycles; prio flipping does not starve it.
- SETTLE=1: EXEC lasts one cycle.
- Operands 0: res=0, oflow=0.
- Max operands: res=(2**BIT-1)**2, oflow=1.
- rst_n low mid-EXEC or mid-DONE: immediate return to reset values; no done pulse; no res update.
- rst_n deassertion with req high: grant on the first edge after release.

Width rules:
- Product is 2*BIT bits, unsigned; no truncation.
- cnt is sized by $clog2(SETTLE+1).

Decomposition:
- Package mult_share_pkg holds:
  - state enum ctrl_state_t {IDLE, EXEC, DONE};
  - localparam MAX_SETTLE=15.
- One natural sub-module: rr_arb2, a combinational two-way round-robin pick (inputs req[1:0] and prio; output winner and valid).
- The multiplier `multiplicador` is instantiated once inside this block.

Test Plan:
- Reset then idle: rst_n=0 with random inputs -> all outputs 0; after release with no req -> busy=0, no done for 20 cycles.
- Single request, BIT=4, SETTLE=2: req0=1, a0=7, b0=9 -> gnt0 at edge G; done0 one cycle after edge G+2; res=63, oflow=1; done1 and gnt1 stay 0.
- Contention: req0=req1=1 from reset, a0=3,b0=5 and a1=15,b1=15 -> first done0 with res=15, oflow=0; then done1 with res=225, oflow=1; four pulses alternate 0,1,0,1.
- Operand change after grant: grant req1 with a1=2,b1=3, then change a1 to 15 during EXEC -> res=6.
- Reset mid-operation: assert rst_n=0 on the second EXEC cycle -> outputs 0 at once; no done; after release, req still high is re-granted and completes with the correct product.
- Edge values: a=0,b=15 -> res=0, oflow=0; a=1,b=15 -> res=15, oflow=0; a=2,b=8 -> res=16, oflow=1; repeat with SETTLE=1 and check done after edge G+1.
